// File: rtl/slave_ctrl_deserializer_pkg.sv
// Shared types for the serial slave control path: FSM states, transfer direction and burst mode.
package slave_ctrl_deserializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ID,
    RW,
    BURST,
    ADDR,
    WDATA,
    SKIP
  } state_e;

  typedef enum logic {
    Read_slave  = 1'b0,
    Write_slave = 1'b1
  } rw_e;

  typedef enum logic {
    non_burst = 1'b0,
    burst     = 1'b1
  } burst_e;

  // Number of leading '1' bits that open a header.
  localparam int unsigned HDR_ONES = 3;

endpackage

// File: rtl/slave_ctrl_deserializer_shift.sv
// MSB-first serial-to-parallel shifter with bit counter; done flags the bit that completes a word.
module serial_shift_in #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] value;
  logic [CW-1:0]    count;

  // word is the value including the bit being sampled now, so it is complete on the done cycle.
  assign word = {value[WIDTH-2:0], bit_in};
  assign done = en && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (en) begin
      value <= word;
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/slave_ctrl_deserializer.sv
// Serial slave front end: decodes the header on control, assembles write words from wD,
// and issues registered write/read strobes.
module slave_ctrl_deserializer
  import slave_ctrl_deserializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter logic [1:0]  SLAVEID       = 2'd1
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     control,
  input  logic                     wD,
  input  logic                     valid,
  input  logic                     last,
  output logic                     ready,
  output logic                     wr_en,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic                     rd_start,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     rd_burst
);

  state_e                   state, next;
  logic [1:0]               cnt;
  logic [1:0]               id_bits;
  rw_e                      rw_q;
  burst_e                   burst_q;
  logic [ADDRESS_WIDTH-1:0] cur_addr;

  logic                     addr_en, addr_done, data_en, data_done, shift_clear;
  logic [ADDRESS_WIDTH-1:0] addr_word;
  logic [DATA_WIDTH-1:0]    data_word;
  logic                     id_ok;

  assign id_ok       = (id_bits == SLAVEID);
  assign shift_clear = (state == IDLE);

  serial_shift_in #(.WIDTH(ADDRESS_WIDTH)) u_addr_shift (
    .clk(clk), .rst_n(rstN), .clear(shift_clear), .en(addr_en),
    .bit_in(control), .word(addr_word), .done(addr_done)
  );

  serial_shift_in #(.WIDTH(DATA_WIDTH)) u_data_shift (
    .clk(clk), .rst_n(rstN), .clear(shift_clear), .en(data_en),
    .bit_in(wD), .word(data_word), .done(data_done)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next    = state;
    ready   = 1'b0;
    addr_en = 1'b0;
    data_en = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (control) next = START;
      end
      START: begin
        if (!control)                         next = IDLE;
        else if (cnt == 2'(HDR_ONES - 1))     next = ID;
      end
      ID:    if (cnt == 2'd1) next = RW;
      RW:    next = BURST;
      BURST: next = ADDR;
      ADDR: begin
        addr_en = 1'b1;
        if (addr_done) begin
          if (!id_ok)                  next = SKIP;
          else if (rw_q == Write_slave) next = WDATA;
          else                          next = IDLE;
        end
      end
      WDATA: begin
        data_en = valid;
        if (data_done && (burst_q == non_burst || last)) next = IDLE;
      end
      SKIP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt      <= '0;
      id_bits  <= '0;
      rw_q     <= Read_slave;
      burst_q  <= non_burst;
      cur_addr <= '0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      wr_addr  <= '0;
      rd_start <= 1'b0;
      rd_addr  <= '0;
      rd_burst <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      rd_start <= 1'b0;
      case (state)
        IDLE:  cnt <= control ? 2'd1 : '0;
        START: cnt <= (control && cnt != 2'(HDR_ONES - 1)) ? cnt + 2'd1 : '0;
        ID: begin
          id_bits <= {id_bits[0], control};
          cnt     <= (cnt == 2'd1) ? '0 : cnt + 2'd1;
        end
        RW:    rw_q    <= rw_e'(control);
        BURST: burst_q <= burst_e'(control);
        ADDR: begin
          if (addr_done) begin
            cur_addr <= addr_word;
            if (id_ok && rw_q == Read_slave) begin
              rd_start <= 1'b1;
              rd_addr  <= addr_word;
              rd_burst <= (burst_q == burst);
            end
          end
        end
        WDATA: begin
          if (data_done) begin
            wr_en    <= 1'b1;
            wr_data  <= data_word;
            wr_addr  <= cur_addr;
            cur_addr <= cur_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_ctrl_deserializer.sv
// Directed bench: a transaction-level model predicts each strobe and the step it must appear in.
module tb_slave_ctrl_deserializer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rstN;
  logic          control, wD, valid, last;
  logic          ready, wr_en, rd_start, rd_burst;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr, rd_addr;

  slave_ctrl_deserializer #(
    .DATA_WIDTH(DW),
    .ADDRESS_WIDTH(AW),
    .SLAVEID(2'd1)
  ) dut (
    .clk(clk), .rstN(rstN), .control(control), .wD(wD), .valid(valid), .last(last),
    .ready(ready), .wr_en(wr_en), .wr_data(wr_data), .wr_addr(wr_addr),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_burst(rd_burst)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_ev_t;

  typedef struct {
    int          due;
    logic [AW-1:0] addr;
    logic          burst;
  } rd_ev_t;

  wr_ev_t        wq[$];
  rd_ev_t        rq[$];
  int            checks   = 0;
  int            failures = 0;
  int            step_no  = 0;
  logic          model_active = 1'b0;
  logic          model_burst  = 1'b0;
  logic [AW-1:0] model_addr   = '0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (step %0d)", name, act, exp, step_no);
    end
  endtask

  task automatic compare();
    if (!rstN) begin
      check("rst_ready", ready, 1);
      check("rst_wr_en", wr_en, 0);
      check("rst_rd_start", rd_start, 0);
    end else begin
      if (wq.size() != 0 && wq[0].due < step_no) begin
        checks++; failures++;
        $display("FAIL wr_missed actual=none expected=step%0d", wq[0].due);
        void'(wq.pop_front());
      end
      if (wq.size() != 0 && wq[0].due == step_no) begin
        check("wr_en", wr_en, 1);
        check("wr_data", wr_data, wq[0].data);
        check("wr_addr", wr_addr, wq[0].addr);
        void'(wq.pop_front());
      end else begin
        check("wr_en_quiet", wr_en, 0);
      end
      if (rq.size() != 0 && rq[0].due < step_no) begin
        checks++; failures++;
        $display("FAIL rd_missed actual=none expected=step%0d", rq[0].due);
        void'(rq.pop_front());
      end
      if (rq.size() != 0 && rq[0].due == step_no) begin
        check("rd_start", rd_start, 1);
        check("rd_addr", rd_addr, rq[0].addr);
        check("rd_burst", rd_burst, rq[0].burst);
        void'(rq.pop_front());
      end else begin
        check("rd_start_quiet", rd_start, 0);
      end
    end
  endtask

  // One clock: drive inputs, let the edge sample them, then compare just after the edge.
  task automatic step(input logic c, input logic d, input logic v, input logic l);
    step_no++;
    control = c; wD = d; valid = v; last = l;
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rb(), 1'b0, rb());
  endtask

  task automatic send_header(input logic [1:0] id, input logic rw, input logic b,
                             input logic [AW-1:0] addr);
    logic [18:0] hdr;
    logic        match;
    hdr   = {3'b111, id, rw, b, addr};
    match = (id == 2'd1);
    for (int i = 18; i >= 0; i--) begin
      if (i == 0 && match && !rw) rq.push_back('{step_no + 1, addr, b});
      step(hdr[i], rb(), rb(), rb());
    end
    model_active = match && rw;
    model_addr   = addr;
    model_burst  = b;
  endtask

  task automatic send_word(input logic [DW-1:0] data, input int gap_at, input int gap_len,
                           input logic last_end, input logic early_last, input logic noise);
    for (int i = DW - 1; i >= 0; i--) begin
      if (i == 0 && model_active) wq.push_back('{step_no + 1, model_addr, data});
      step(noise ? ~data[i] : 1'b0, data[i], 1'b1,
           (i == 0) ? last_end : ((i == DW - 1) ? early_last : 1'b0));
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) step(1'b0, rb(), 1'b0, rb());
    end
    if (model_active) begin
      model_addr = model_addr + 12'd1;
      if (!model_burst || last_end) model_active = 1'b0;
    end
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    wq.delete();
    rq.delete();
    model_active = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_burst", rd_burst, 0);
    rstN = 1'b1;
    idle(2);
  endtask

  initial begin
    rstN = 1'b0; control = 1'b0; wD = 1'b0; valid = 1'b0; last = 1'b0;
    do_reset();

    // Single write of 0xA5 to 0x005, control toggling during data must be ignored
    send_header(2'b01, 1'b1, 1'b0, 12'h005);
    send_word(8'hA5, -1, 0, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("a5_ready", ready, 1);
    check("a5_data", wr_data, 8'hA5);
    check("a5_addr", wr_addr, 12'h005);
    idle(2);

    // Burst write wrapping 0xFFF -> 0x000 -> 0x001; early last on word 1 is ignored
    send_header(2'b01, 1'b1, 1'b1, 12'hFFF);
    send_word(8'h11, -1, 0, 1'b0, 1'b1, 1'b1);
    send_word(8'h22, -1, 0, 1'b0, 1'b0, 1'b1);
    send_word(8'h33, -1, 0, 1'b1, 1'b0, 1'b1);
    idle(1);
    check("burst_ready", ready, 1);
    check("burst_last_addr", wr_addr, 12'h001);
    check("burst_last_data", wr_data, 8'h33);
    idle(2);

    // ID mismatch (10) with write data following: nothing may be strobed
    send_header(2'b10, 1'b1, 1'b0, 12'h0AA);
    send_word(8'h55, -1, 0, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("mismatch_ready", ready, 1);
    check("mismatch_hold_data", wr_data, 8'h33);
    send_header(2'b00, 1'b0, 1'b1, 12'h321);
    idle(3);
    check("mismatch_rd_hold", rd_addr, 12'h000);

    // Burst read of 0x123, then a non-burst read of 0x456
    send_header(2'b01, 1'b0, 1'b1, 12'h123);
    check("rd_ready_after", ready, 1);
    idle(2);
    check("rd_addr_hold", rd_addr, 12'h123);
    check("rd_burst_hold", rd_burst, 1);
    send_header(2'b01, 1'b0, 1'b0, 12'h456);
    idle(2);
    check("rd2_burst", rd_burst, 0);

    // Write 0x3C with valid low for 5 cycles mid-word
    send_header(2'b01, 1'b1, 1'b0, 12'h0C0);
    send_word(8'h3C, 4, 5, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("gap_data", wr_data, 8'h3C);
    check("gap_addr", wr_addr, 12'h0C0);
    idle(2);

    // Reset after 4 data bits, then a clean write of 0x7E
    send_header(2'b01, 1'b1, 1'b0, 12'h200);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
    send_header(2'b01, 1'b1, 1'b0, 12'h201);
    send_word(8'h7E, -1, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("post_rst_data", wr_data, 8'h7E);
    check("post_rst_addr", wr_addr, 12'h201);

    // Reset mid-header discards it
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Glitch 1,1,0 on control must fall back to IDLE; following data is ignored
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("glitch_ready", ready, 1);
    send_word(8'h99, -1, 0, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("glitch_ready_after", ready, 1);
    check("glitch_no_write", wr_data, 8'h00);

    idle(3);
    check("wr_queue_drained", wq.size(), 0);
    check("rd_queue_drained", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
